knn_query_sequencer: RTL and testbench



---
 rtl/knn_pkg.sv | 20 ++
 rtl/knn_agree_count.sv | 20 ++
 rtl/knn_query_sequencer.sv | 140 ++++++++++++++
 tb/tb_knn_query_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared constants and types for the knn_classification front-end sequencer.
package knn_pkg;

    localparam int FEAT_W      = 16;
    localparam int NUM_FEAT    = 4;
    localparam int CLASS_W     = 4;
    localparam int K           = 5;
    localparam int NUM_CLASSES = 3;
    localparam int IDX_W       = $clog2(NUM_FEAT);

    typedef enum logic [1:0] {
        LOAD,
        KRST,
        RUN,
        OUT
    } seq_state_t;

    typedef logic [CLASS_W-1:0] class_t;

endpackage

// File: rtl/knn_agree_count.sv
// Counts how many of the K neighbour classes equal the reference class.
module knn_agree_count
    import knn_pkg::*;
(
    input  class_t [K-1:0] nbrs,
    input  class_t         ref_class,
    output logic   [2:0]   agree
);

    // Popcount of per-neighbour equality.
    always_comb begin
        agree = '0;
        for (int i = 0; i < K; i++) begin
            if (nbrs[i] == ref_class) begin
                agree = agree + 3'd1;
            end
        end
    end

endmodule

// File: rtl/knn_query_sequencer.sv
// Host-side sequencer for knn_classification: packs one query, pulses the
// classifier reset, waits out its fixed latency and presents the result.
//
// state | meaning
// LOAD  | accepting feature words into the test vector
// KRST  | classifier held in reset
// RUN   | classifier evaluating, counting its latency
// OUT   | result presented, waiting for handshake
module knn_query_sequencer
    import knn_pkg::*;
#(
    parameter int RST_CYCLES  = 1,
    parameter int KNN_LATENCY = 158
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       s_feat_valid,
    output logic                       s_feat_ready,
    input  logic [FEAT_W-1:0]          s_feat_data,
    output logic                       knn_rst_n,
    output logic [NUM_FEAT*FEAT_W-1:0] knn_test_vector,
    input  class_t                     knn_c1,
    input  class_t                     knn_c2,
    input  class_t                     knn_c3,
    input  class_t                     knn_c4,
    input  class_t                     knn_c5,
    input  class_t                     knn_final_class,
    output logic                       m_res_valid,
    input  logic                       m_res_ready,
    output class_t                     m_res_class,
    output logic [K*CLASS_W-1:0]       m_res_nbrs,
    output logic [2:0]                 m_res_agree,
    output logic                       m_res_invalid,
    output logic                       busy,
    output logic [15:0]                query_count
);

    localparam int RUN_W  = $clog2(KNN_LATENCY + 1);
    localparam int KRST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RUN_W-1:0]  RUN_LOAD  = RUN_W'(KNN_LATENCY - 1);
    localparam logic [KRST_W-1:0] KRST_LOAD = KRST_W'(RST_CYCLES - 1);

    seq_state_t        state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [KRST_W-1:0] krst_cnt;
    logic [RUN_W-1:0]  run_cnt;
    class_t [K-1:0]    nbr_vec;
    logic [2:0]        agree_now;
    logic              feat_acc, res_hs, last_feat, run_done;

    // A word arriving together with flush is dropped.
    assign feat_acc  = s_feat_valid && s_feat_ready && !flush;
    assign res_hs    = m_res_valid && m_res_ready;
    assign last_feat = (idx == IDX_W'(NUM_FEAT - 1));
    assign run_done  = (run_cnt == '0);
    assign nbr_vec   = {knn_c1, knn_c2, knn_c3, knn_c4, knn_c5};

    knn_agree_count u_agree (
        .nbrs      (nbr_vec),
        .ref_class (knn_final_class),
        .agree     (agree_now)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // Next-state decode and state-derived stream flags.
    always_comb begin
        state_nxt    = state;
        s_feat_ready = (state == LOAD);
        busy         = (state != LOAD);
        case (state)
            LOAD: if (feat_acc && last_feat)  state_nxt = KRST;
            KRST: if (krst_cnt == '0)         state_nxt = RUN;
            RUN:  if (run_done)               state_nxt = OUT;
            OUT:  if (res_hs)                 state_nxt = LOAD;
            default:                          state_nxt = LOAD;
        endcase
        if (flush) state_nxt = LOAD;
    end

    // Feature index and phase down-counters; counters reload whenever idle in other states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            krst_cnt <= KRST_LOAD;
            run_cnt  <= RUN_LOAD;
        end else begin
            if (flush)         idx <= '0;
            else if (feat_acc) idx <= last_feat ? '0 : idx + 1'b1;
            krst_cnt <= (state == KRST) ? krst_cnt - 1'b1 : KRST_LOAD;
            run_cnt  <= (state == RUN)  ? run_cnt - 1'b1  : RUN_LOAD;
        end
    end

    // Test vector packing, slot 0 in the MSBs; classifier reset released only in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            knn_test_vector <= '0;
            knn_rst_n       <= 1'b0;
        end else begin
            knn_rst_n <= (state_nxt == RUN);
            if (feat_acc) begin
                for (int i = 0; i < NUM_FEAT; i++) begin
                    if (idx == IDX_W'(i)) begin
                        knn_test_vector[(NUM_FEAT-1-i)*FEAT_W +: FEAT_W] <= s_feat_data;
                    end
                end
            end
        end
    end

    // Result capture at the end of RUN, hold until handshake, completed-query count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res_valid   <= 1'b0;
            m_res_class   <= '0;
            m_res_nbrs    <= '0;
            m_res_agree   <= '0;
            m_res_invalid <= 1'b0;
            query_count   <= '0;
        end else if (flush) begin
            m_res_valid <= 1'b0;
        end else if (state == RUN && run_done) begin
            m_res_valid   <= 1'b1;
            m_res_class   <= knn_final_class;
            m_res_nbrs    <= nbr_vec;
            m_res_agree   <= agree_now;
            m_res_invalid <= (knn_final_class >= CLASS_W'(NUM_CLASSES));
        end else if (res_hs) begin
            m_res_valid <= 1'b0;
            query_count <= query_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Self-checking bench for knn_query_sequencer with a stubbed classifier.
module tb_knn_query_sequencer;
    import knn_pkg::*;

    localparam int LAT_EXP = 159;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         s_feat_valid = 1'b0;
    logic         s_feat_ready;
    logic [15:0]  s_feat_data = '0;
    logic         knn_rst_n;
    logic [63:0]  knn_test_vector;
    logic [19:0]  stub_nbrs = '0;
    class_t       stub_final = '0;
    logic         m_res_valid;
    logic         m_res_ready = 1'b0;
    class_t       m_res_class;
    logic [19:0]  m_res_nbrs;
    logic [2:0]   m_res_agree;
    logic         m_res_invalid;
    logic         busy;
    logic [15:0]  query_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_qc = 0;

    knn_query_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .s_feat_valid    (s_feat_valid),
        .s_feat_ready    (s_feat_ready),
        .s_feat_data     (s_feat_data),
        .knn_rst_n       (knn_rst_n),
        .knn_test_vector (knn_test_vector),
        .knn_c1          (stub_nbrs[19:16]),
        .knn_c2          (stub_nbrs[15:12]),
        .knn_c3          (stub_nbrs[11:8]),
        .knn_c4          (stub_nbrs[7:4]),
        .knn_c5          (stub_nbrs[3:0]),
        .knn_final_class (stub_final),
        .m_res_valid     (m_res_valid),
        .m_res_ready     (m_res_ready),
        .m_res_class     (m_res_class),
        .m_res_nbrs      (m_res_nbrs),
        .m_res_agree     (m_res_agree),
        .m_res_invalid   (m_res_invalid),
        .busy            (busy),
        .query_count     (query_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: expected {class, nbrs, agree, invalid} from the classifier outputs.
    function automatic logic [27:0] model_res(input logic [19:0] nb, input class_t fin);
        int cnt = 0;
        for (int i = 0; i < 5; i++) if (nb[i*4 +: 4] == fin) cnt++;
        return {fin, nb, 3'(cnt), (int'(fin) >= NUM_CLASSES)};
    endfunction

    function automatic logic [19:0] rand_nbrs();
        logic [19:0] r;
        for (int i = 0; i < 5; i++) r[i*4 +: 4] = 4'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream one query in; e is the cycle count at the edge that took the last word.
    task automatic send_query(input logic [63:0] v, output int e);
        for (int i = 0; i < 4; i++) begin
            s_feat_valid = 1'b1;
            s_feat_data  = v[63-16*i -: 16];
            tick();
        end
        s_feat_valid = 1'b0;
        e = cyc;
    endtask

    // Wait for m_res_valid, measuring latency and classifier-run cycles.
    task automatic wait_result(input int e, output int lat, output int highs, output bit to);
        highs = 0;
        lat = -1;
        to = 1'b1;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (knn_rst_n) highs++;
            if (m_res_valid) begin
                lat = cyc - e;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic handshake();
        m_res_ready = 1'b1;
        tick();
        m_res_ready = 1'b0;
        exp_qc = (exp_qc + 1) % 65536;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({s_feat_ready, knn_rst_n, busy, m_res_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags: got ready/krst/busy/valid=%b want 1000",
                     {s_feat_ready, knn_rst_n, busy, m_res_valid});
        end
        checks++;
        if ({knn_test_vector, query_count, m_res_class, m_res_nbrs, m_res_agree, m_res_invalid} !== '0) begin
            failures++;
            $display("FAIL reset_regs: vec=%h qc=%0d res=%h/%h/%0d/%b want all 0",
                     knn_test_vector, query_count, m_res_class, m_res_nbrs, m_res_agree, m_res_invalid);
        end
        rst_n = 1'b1;
        tick();
        m_res_ready = 1'b1;
        tick();
        tick();
        m_res_ready = 1'b0;
        checks++;
        if (query_count !== 16'd0 || m_res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: qc=%0d valid=%b busy=%b want 0 0 0", query_count, m_res_valid, busy);
        end
    endtask

    task automatic test_basic();
        int e, lat, highs;
        bit to;
        logic [63:0] v;
        v = {16'd100, 16'd200, 16'd150, 16'd50};
        stub_nbrs  = {4'd1, 4'd1, 4'd2, 4'd1, 4'd0};
        stub_final = 4'd1;
        send_query(v, e);
        checks++;
        if (knn_test_vector !== v) begin
            failures++;
            $display("FAIL basic_vector: got %h want %h", knn_test_vector, v);
        end
        checks++;
        if (knn_rst_n !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_krst: knn_rst_n=%b busy=%b want 0 1", knn_rst_n, busy);
        end
        wait_result(e, lat, highs, to);
        checks++;
        if (to || lat != LAT_EXP) begin
            failures++;
            $display("FAIL basic_latency: got %0d (timeout=%0d) want %0d", lat, to, LAT_EXP);
        end
        checks++;
        if (highs != 158) begin
            failures++;
            $display("FAIL basic_run_cycles: got %0d want 158", highs);
        end
        checks++;
        if (m_res_class !== 4'd1 || m_res_nbrs !== 20'h11210) begin
            failures++;
            $display("FAIL basic_class_nbrs: got %0d %h want 1 11210", m_res_class, m_res_nbrs);
        end
        checks++;
        if (m_res_agree !== 3'd3 || m_res_invalid !== 1'b0) begin
            failures++;
            $display("FAIL basic_agree: got agree=%0d inv=%b want 3 0", m_res_agree, m_res_invalid);
        end
        checks++;
        if (query_count !== 16'd0) begin
            failures++;
            $display("FAIL basic_qc_before: got %0d want 0", query_count);
        end
        handshake();
        checks++;
        if (query_count !== 16'd1 || m_res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_handshake: qc=%0d valid=%b busy=%b want 1 0 0",
                     query_count, m_res_valid, busy);
        end
    endtask

    task automatic test_hold();
        int e, lat, highs;
        bit to;
        logic [63:0] v;
        logic [27:0] exp;
        v = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        stub_nbrs  = rand_nbrs();
        stub_final = 4'($urandom_range(0, 2));
        exp = model_res(stub_nbrs, stub_final);
        send_query(v, e);
        wait_result(e, lat, highs, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL hold_timeout: no result within bound");
        end
        for (int n = 0; n < 20; n++) begin
            stub_nbrs    = rand_nbrs() ^ 20'hfffff;
            stub_final   = 4'($urandom);
            s_feat_valid = 1'b1;
            s_feat_data  = 16'($urandom);
            tick();
            checks++;
            if ({m_res_class, m_res_nbrs, m_res_agree, m_res_invalid} !== exp || m_res_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_result: got %h valid=%b want %h valid=1",
                         {m_res_class, m_res_nbrs, m_res_agree, m_res_invalid}, m_res_valid, exp);
            end
            checks++;
            if (s_feat_ready !== 1'b0 || knn_test_vector !== v) begin
                failures++;
                $display("FAIL hold_no_accept: ready=%b vec=%h want 0 %h", s_feat_ready, knn_test_vector, v);
            end
        end
        s_feat_valid = 1'b0;
        handshake();
        checks++;
        if (busy !== 1'b0 || s_feat_ready !== 1'b1 || query_count !== 16'(exp_qc)) begin
            failures++;
            $display("FAIL hold_release: busy=%b ready=%b qc=%0d want 0 1 %0d",
                     busy, s_feat_ready, query_count, exp_qc);
        end
    endtask

    task automatic test_flush();
        int e;
        logic [63:0] v;
        s_feat_valid = 1'b1;
        s_feat_data = 16'haaaa;
        tick();
        s_feat_data = 16'hbbbb;
        tick();
        s_feat_data = 16'hdead;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        s_feat_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_load: busy=%b want 0", busy);
        end
        v = {16'd1, 16'd2, 16'd3, 16'd4};
        send_query(v, e);
        checks++;
        if (knn_test_vector !== v || busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_vector: got %h busy=%b want %h 1", knn_test_vector, busy, v);
        end
        for (int n = 0; n < 81; n++) tick();
        checks++;
        if (knn_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL flush_in_run: knn_rst_n=%b want 1", knn_rst_n);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (knn_rst_n !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_run_abort: knn_rst_n=%b busy=%b want 0 0", knn_rst_n, busy);
        end
        begin
            int seen = 0;
            for (int n = 0; n < 200; n++) begin
                tick();
                if (m_res_valid) seen++;
            end
            checks++;
            if (seen != 0 || query_count !== 16'(exp_qc) || knn_test_vector !== v) begin
                failures++;
                $display("FAIL flush_no_result: valid_cycles=%0d qc=%0d vec=%h want 0 %0d %h",
                         seen, query_count, knn_test_vector, exp_qc, v);
            end
        end
    endtask

    task automatic test_classes();
        int e, lat, highs;
        bit to;
        logic [27:0] exp;
        stub_nbrs  = rand_nbrs();
        stub_final = 4'd3;
        exp = model_res(stub_nbrs, stub_final);
        send_query(64'h0123_4567_89ab_cdef, e);
        wait_result(e, lat, highs, to);
        checks++;
        if (to || m_res_invalid !== 1'b1 || {m_res_class, m_res_nbrs, m_res_agree, m_res_invalid} !== exp) begin
            failures++;
            $display("FAIL class_invalid: got %h inv=%b want %h inv=1",
                     {m_res_class, m_res_nbrs, m_res_agree, m_res_invalid}, m_res_invalid, exp);
        end
        handshake();
        stub_nbrs  = '0;
        stub_final = 4'd0;
        send_query(64'hffff_0000_ffff_0000, e);
        wait_result(e, lat, highs, to);
        checks++;
        if (to || m_res_agree !== 3'd5 || m_res_invalid !== 1'b0) begin
            failures++;
            $display("FAIL class_agree5: got agree=%0d inv=%b want 5 0", m_res_agree, m_res_invalid);
        end
        handshake();
    endtask

    task automatic test_random();
        int e, lat, highs;
        bit to;
        logic [63:0] v;
        logic [27:0] exp;
        for (int q = 0; q < 6; q++) begin
            v = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            stub_nbrs  = rand_nbrs();
            stub_final = 4'($urandom_range(0, 4));
            exp = model_res(stub_nbrs, stub_final);
            send_query(v, e);
            checks++;
            if (knn_test_vector !== v) begin
                failures++;
                $display("FAIL rand_vector[%0d]: got %h want %h", q, knn_test_vector, v);
            end
            wait_result(e, lat, highs, to);
            checks++;
            if (to || lat != LAT_EXP || highs != 158) begin
                failures++;
                $display("FAIL rand_timing[%0d]: lat=%0d run=%0d want %0d 158", q, lat, highs, LAT_EXP);
            end
            for (int d = $urandom_range(0, 5); d > 0; d--) tick();
            checks++;
            if ({m_res_class, m_res_nbrs, m_res_agree, m_res_invalid} !== exp) begin
                failures++;
                $display("FAIL rand_result[%0d]: got %h want %h", q,
                         {m_res_class, m_res_nbrs, m_res_agree, m_res_invalid}, exp);
            end
            handshake();
            checks++;
            if (query_count !== 16'(exp_qc)) begin
                failures++;
                $display("FAIL rand_qc[%0d]: got %0d want %0d", q, query_count, exp_qc);
            end
        end
    endtask

    task automatic test_async_reset();
        int e, lat, highs;
        bit to;
        logic [63:0] v;
        logic [27:0] exp;
        send_query(64'h1111_2222_3333_4444, e);
        for (int n = 0; n < 50; n++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_qc = 0;
        checks++;
        if ({s_feat_ready, knn_rst_n, busy, m_res_valid} !== 4'b1000 ||
            knn_test_vector !== '0 || query_count !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: flags=%b vec=%h qc=%0d want 1000 0 0",
                     {s_feat_ready, knn_rst_n, busy, m_res_valid}, knn_test_vector, query_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
        v = {16'd7, 16'd8, 16'd9, 16'd10};
        stub_nbrs  = rand_nbrs();
        stub_final = 4'($urandom_range(0, 2));
        exp = model_res(stub_nbrs, stub_final);
        send_query(v, e);
        wait_result(e, lat, highs, to);
        checks++;
        if (to || lat != LAT_EXP || {m_res_class, m_res_nbrs, m_res_agree, m_res_invalid} !== exp) begin
            failures++;
            $display("FAIL async_requery: lat=%0d res=%h want %0d %h", lat,
                     {m_res_class, m_res_nbrs, m_res_agree, m_res_invalid}, LAT_EXP, exp);
        end
        handshake();
        checks++;
        if (query_count !== 16'(exp_qc)) begin
            failures++;
            $display("FAIL async_qc: got %0d want %0d", query_count, exp_qc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_flush();
        test_classes();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
